ro_pair_compare: RTL and testbench

Measurement stage that sits directly downstream of a pair of ring oscillators in the delay-based PUF. It gates both oscillators on through their enable inputs and counts the rising edges of each oscillator output over a fixed window of system clocks. It then compares the two counts and emits one PUF response bit. The counts are also exposed so firmware can check reliability margin.

---
 rtl/ro_pair_compare.sv | 135 +++++++++++++
 tb/tb_ro_pair_compare.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair measurement: gate both ROs on, count synchronized rising edges over a window, compare.
// Latency SETTLE_CYCLES+WINDOW+1 clk from accepted start to done; no backpressure, start ignored while busy.
module ro_pair_compare #(
  parameter int CNT_WIDTH     = 16,
  parameter int WINDOW        = 1000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic                 ro_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 response,
  output logic                 tie,
  output logic [CNT_WIDTH-1:0] count_a,
  output logic [CNT_WIDTH-1:0] count_b
);

  localparam int TMAX = (WINDOW > SETTLE_CYCLES) ? WINDOW : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0]        SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]        WINDOW_LOAD = TW'(WINDOW - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [2:0]           pipe_a_q, pipe_a_d;
  logic [2:0]           pipe_b_q, pipe_b_d;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic [CNT_WIDTH-1:0] count_a_q, count_a_d;
  logic [CNT_WIDTH-1:0] count_b_q, count_b_d;
  logic                 response_q, response_d;
  logic                 tie_q, tie_d;
  logic                 done_q, done_d;
  logic                 ro_enable_q, ro_enable_d;
  logic                 edge_a, edge_b;

  // Bits [1:0] are the synchronizer, bit 2 is the edge-detect history.
  assign pipe_a_d = {pipe_a_q[1:0], ro_a};
  assign pipe_b_d = {pipe_b_q[1:0], ro_b};
  assign edge_a   = pipe_a_q[1] & ~pipe_a_q[2];
  assign edge_b   = pipe_b_q[1] & ~pipe_b_q[2];

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    response_d = response_q;
    tie_d      = tie_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          tmr_d   = SETTLE_LOAD;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = MEASURE;
          tmr_d   = WINDOW_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      MEASURE: begin
        if (edge_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + 1'b1;
        if (edge_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + 1'b1;
        // Results latch on the edge entering DONE, including this cycle's edges.
        if (tmr_q == '0) begin
          state_d    = DONE;
          count_a_d  = cnt_a_d;
          count_b_d  = cnt_b_d;
          response_d = cnt_a_d > cnt_b_d;
          tie_d      = cnt_a_d == cnt_b_d;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ro_enable_d = (state_d == SETTLE) || (state_d == MEASURE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      pipe_a_q    <= '0;
      pipe_b_q    <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      count_a_q   <= '0;
      count_b_q   <= '0;
      response_q  <= 1'b0;
      tie_q       <= 1'b0;
      done_q      <= 1'b0;
      ro_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pipe_a_q    <= pipe_a_d;
      pipe_b_q    <= pipe_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      count_a_q   <= count_a_d;
      count_b_q   <= count_b_d;
      response_q  <= response_d;
      tie_q       <= tie_d;
      done_q      <= done_d;
      ro_enable_q <= ro_enable_d;
    end
  end

  assign ro_enable = ro_enable_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign response  = response_q;
  assign tie       = tie_q;
  assign count_a   = count_a_q;
  assign count_b   = count_b_q;

endmodule

// File: tb/tb_ro_pair_compare.sv
// Directed bench for ro_pair_compare: clk 10 ns, CNT_WIDTH=5, WINDOW=120, SETTLE_CYCLES=4.
// Oscillators are free-running square waves offset 2 ns from clk edges.
`timescale 1ns/1ps
module tb_ro_pair_compare;
  localparam int CW  = 5;
  localparam int WIN = 120;
  localparam int ST  = 4;
  localparam int LAT = ST + WIN + 1;
  localparam int PER = ST + WIN + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ro_a = 1'b0;
  logic          ro_b_gen = 1'b0;
  logic          tie_mode = 1'b0;
  wire           ro_b = tie_mode ? ro_a : ro_b_gen;
  logic          ro_enable, busy, done, response, tie;
  logic [CW-1:0] count_a, count_b;
  int            half_a = 20;
  int            half_b = 30;
  int            checks = 0;
  int            errors = 0;

  ro_pair_compare #(.CNT_WIDTH(CW), .WINDOW(WIN), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .reset(reset), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_enable(ro_enable), .busy(busy), .done(done), .response(response),
    .tie(tie), .count_a(count_a), .count_b(count_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2;
    forever begin
      if (half_a == 0) begin ro_a = 1'b0; #1; end
      else begin #(half_a) ro_a = ~ro_a; end
    end
  end

  initial begin
    #2;
    forever begin
      if (half_b == 0) begin ro_b_gen = 1'b0; #1; end
      else begin #(half_b) ro_b_gen = ~ro_b_gen; end
    end
  end

  // Pulses start in IDLE and returns negedges from acceptance to done.
  task automatic run_meas(output int lat, output bit en_ok);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    en_ok = 1'b1;
    while (!done && lat < 1000) begin
      if (!ro_enable || !busy) en_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || ro_enable !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b en=%b done=%b want 0 0 0", busy, ro_enable, done);
    end
    checks++; if (count_a !== '0 || count_b !== '0 || response !== 1'b0 || tie !== 1'b0) begin
      errors++; $display("FAIL reset_results a=%0d b=%0d resp=%b tie=%b want all 0", count_a, count_b, response, tie);
    end
  endtask

  task automatic test_basic;
    int lat; bit en_ok;
    half_a = 20; half_b = 30; tie_mode = 1'b0;
    run_meas(lat, en_ok);
    checks++; if (lat !== LAT) begin
      errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT);
    end
    checks++; if (!en_ok || ro_enable !== 1'b0) begin
      errors++; $display("FAIL basic_enable window_ok=%b en_at_done=%b want 1 0", en_ok, ro_enable);
    end
    checks++; if (count_a < 29 || count_a > 31 || count_b < 19 || count_b > 21) begin
      errors++; $display("FAIL basic_counts a=%0d b=%0d want 30+-1 20+-1", count_a, count_b);
    end
    checks++; if (response !== 1'b1 || tie !== 1'b0) begin
      errors++; $display("FAIL basic_cmp resp=%b tie=%b want 1 0", response, tie);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_tie;
    int lat; bit en_ok;
    half_a = 25; tie_mode = 1'b1;
    run_meas(lat, en_ok);
    checks++; if (count_a !== count_b || count_a < 23 || count_a > 25) begin
      errors++; $display("FAIL tie_counts a=%0d b=%0d want equal 24+-1", count_a, count_b);
    end
    checks++; if (tie !== 1'b1 || response !== 1'b0) begin
      errors++; $display("FAIL tie_flags tie=%b resp=%b want 1 0", tie, response);
    end
    tie_mode = 1'b0;
  endtask

  task automatic test_saturation;
    int lat; bit en_ok;
    half_a = 10; half_b = 100;
    run_meas(lat, en_ok);
    checks++; if (count_a !== 5'd31) begin
      errors++; $display("FAIL sat_count_a got=%0d want=31", count_a);
    end
    checks++; if (count_b < 5 || count_b > 7 || response !== 1'b1 || tie !== 1'b0) begin
      errors++; $display("FAIL sat_count_b b=%0d resp=%b tie=%b want 6+-1 1 0", count_b, response, tie);
    end
  endtask

  task automatic test_reset_mid;
    int lat; bit en_ok; bit saw_done;
    half_a = 20; half_b = 30;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (64) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || ro_enable !== 1'b0 || done !== 1'b0 || count_a !== '0 ||
                  count_b !== '0 || response !== 1'b0 || tie !== 1'b0) begin
      errors++; $display("FAIL midreset_clear busy=%b en=%b done=%b a=%0d b=%0d resp=%b tie=%b want all 0",
                         busy, ro_enable, done, count_a, count_b, response, tie);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin
      errors++; $display("FAIL midreset_no_done saw_done=%b want 0", saw_done);
    end
    run_meas(lat, en_ok);
    checks++; if (lat !== LAT || count_a < 29 || count_a > 31 || count_b < 19 || count_b > 21 || response !== 1'b1) begin
      errors++; $display("FAIL midreset_rerun lat=%0d a=%0d b=%0d resp=%b want %0d 30+-1 20+-1 1",
                         lat, count_a, count_b, response, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0; int last = 0; int bad_gap = 0; int hold_bad = 0;
    logic [CW-1:0] ha, hb; logic hr;
    ha = '0; hb = '0; hr = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0 && i != LAT) bad_gap++;
        if (ndone > 0 && i - last != PER) bad_gap++;
        last = i; ndone++;
        ha = count_a; hb = count_b; hr = response;
      end else if (ndone > 0 && (count_a !== ha || count_b !== hb || response !== hr)) begin
        hold_bad++;
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 3 || bad_gap !== 0) begin
      errors++; $display("FAIL b2b_cadence dones=%0d bad_gaps=%0d want 3 0", ndone, bad_gap);
    end
    checks++; if (hold_bad !== 0) begin
      errors++; $display("FAIL b2b_hold changed_cycles=%0d want 0", hold_bad);
    end
    checks++; if (count_a < 29 || count_a > 31 || count_b < 19 || count_b > 21) begin
      errors++; $display("FAIL b2b_counts a=%0d b=%0d want 30+-1 20+-1", count_a, count_b);
    end
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain busy=%b want 0", busy);
    end
  endtask

  task automatic test_disabled;
    int lat; bit en_ok;
    half_a = 0; half_b = 0;
    run_meas(lat, en_ok);
    checks++; if (lat !== LAT || count_a !== '0 || count_b !== '0) begin
      errors++; $display("FAIL disabled_counts lat=%0d a=%0d b=%0d want %0d 0 0", lat, count_a, count_b, LAT);
    end
    checks++; if (tie !== 1'b1 || response !== 1'b0) begin
      errors++; $display("FAIL disabled_flags tie=%b resp=%b want 1 0", tie, response);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_tie;
    test_saturation;
    test_reset_mid;
    test_back_to_back;
    test_disabled;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
